// File: rtl/decode_scanner_if.sv
// Bus between the decode scanner and its surroundings: scan control, decoder
// select/one-hot pair, and scan result.
interface decode_scanner_if #(
    parameter int ADDR_W = 3
);
    localparam int N = 2 ** ADDR_W;

    logic              start;
    logic [N-1:0]      skip_mask;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [N-1:0]      y;
    logic              busy;
    logic              done;
    logic [N-1:0]      err_mask;
    logic [ADDR_W:0]   err_count;

    // The scanner side.
    modport master (
        input  start, skip_mask, y,
        output addr, addr_valid, busy, done, err_mask, err_count
    );

    // The controller and decoder side.
    modport slave (
        output start, skip_mask, y,
        input  addr, addr_valid, busy, done, err_mask, err_count
    );
endinterface

// File: rtl/decode_scanner.sv
// Address sequencer for the one-hot decoder: steps every unskipped select value,
// holds it for DWELL cycles and flags addresses whose one-hot output is wrong.
module decode_scanner #(
    parameter int ADDR_W = 3,
    parameter int DWELL  = 2
) (
    input logic              clk,
    input logic              rst_n,
    decode_scanner_if.master bus
);
    localparam int N     = 2 ** ADDR_W;
    localparam int CNT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;
    logic [N-1:0]      skip_q;

    logic              found_first;
    logic              found_next;
    logic [ADDR_W-1:0] first_idx;
    logic [ADDR_W-1:0] next_idx;
    logic [N-1:0]      expected;

    // Descending search so the last hit is the lowest qualifying address.
    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        found_first = 1'b0;
        first_idx   = '0;
        found_next  = 1'b0;
        next_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!bus.skip_mask[i]) begin
                found_first = 1'b1;
                first_idx   = ADDR_W'(i);
            end
            if (!skip_q[i] && (i > int'(idx))) begin
                found_next = 1'b1;
                next_idx   = ADDR_W'(i);
            end
        end
    end

    assign expected = {{(N-1){1'b0}}, 1'b1} << idx;

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            cnt            <= '0;
            skip_q         <= '0;
            bus.addr       <= '0;
            bus.addr_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err_mask   <= '0;
            bus.err_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.err_mask  <= '0;
                        bus.err_count <= '0;
                        skip_q        <= bus.skip_mask;
                        cnt           <= '0;
                        if (found_first) begin
                            idx            <= first_idx;
                            bus.addr       <= first_idx;
                            bus.addr_valid <= 1'b1;
                            bus.busy       <= 1'b1;
                            state          <= S_DRIVE;
                        end else begin
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (cnt == CNT_W'(DWELL - 1)) begin
                        // Case inequality so an X/Z from an undecoded select counts as an error.
                        if (bus.y !== expected) begin
                            bus.err_mask[idx] <= 1'b1;
                            bus.err_count     <= bus.err_count + (ADDR_W+1)'(1);
                        end
                        cnt <= '0;
                        if (found_next) begin
                            idx      <= next_idx;
                            bus.addr <= next_idx;
                        end else begin
                            bus.addr       <= '0;
                            bus.addr_valid <= 1'b0;
                            bus.busy       <= 1'b0;
                            bus.done       <= 1'b1;
                            state          <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_scanner.sv
// Bench for decode_scanner: two instances (DWELL=2 and DWELL=1) driving behavioural
// decoder models; expected addresses and scan results are queued and popped on output.
module tb_decode_scanner;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_scanner_if #(.ADDR_W(3)) bus2 ();
    decode_scanner_if #(.ADDR_W(3)) bus1 ();

    decode_scanner #(.ADDR_W(3), .DWELL(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));
    decode_scanner #(.ADDR_W(3), .DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    // Decoder models: 0 correct, 1 missing case for 6, 2 wrong at 1, 3 stuck at zero.
    int mode2 = 0;
    int mode1 = 0;

    function automatic logic [7:0] dec(input logic [2:0] a, input int mode);
        logic [7:0] one;
        one = 8'd1 << a;
        case (mode)
            1:       return (a == 3'd6) ? 8'bx : one;
            2:       return (a == 3'd1) ? 8'h00 : one;
            3:       return 8'h00;
            default: return one;
        endcase
    endfunction

    assign bus2.y = dec(bus2.addr, mode2);
    assign bus1.y = dec(bus1.addr, mode1);

    // Observation mux onto whichever instance the current step exercises.
    bit         sel;
    logic [2:0] s_addr;
    logic       s_valid, s_busy, s_done;
    logic [7:0] s_mask;
    logic [3:0] s_cnt;
    assign s_addr  = sel ? bus1.addr       : bus2.addr;
    assign s_valid = sel ? bus1.addr_valid : bus2.addr_valid;
    assign s_busy  = sel ? bus1.busy       : bus2.busy;
    assign s_done  = sel ? bus1.done       : bus2.done;
    assign s_mask  = sel ? bus1.err_mask   : bus2.err_mask;
    assign s_cnt   = sel ? bus1.err_count  : bus2.err_count;

    typedef struct {
        logic [7:0] mask;
        logic [3:0] cnt;
        int         done_cyc;
    } result_t;

    int      addr_q[$];
    result_t res_q[$];
    int      checks = 0;
    int      passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"},  s_addr,  0);
        check({tag, "_valid"}, s_valid, 0);
        check({tag, "_busy"},  s_busy,  0);
        check({tag, "_done"},  s_done,  0);
        check({tag, "_mask"},  s_mask,  0);
        check({tag, "_cnt"},   s_cnt,   0);
    endtask

    task automatic drive_start(input bit on1, input logic v);
        if (on1) bus1.start = v;
        else     bus2.start = v;
    endtask

    task automatic drive_skip(input bit on1, input logic [7:0] v);
        if (on1) bus1.skip_mask = v;
        else     bus2.skip_mask = v;
    endtask

    task automatic scan(input bit on1, input logic [7:0] skip, input bit retrig,
                        input logic [7:0] exp_mask, input logic [3:0] exp_cnt,
                        input string tag);
        int      dwell = on1 ? 1 : 2;
        int      k = 0;
        int      cyc;
        bit      seen = 1'b0;
        result_t r;
        sel = on1;
        for (int i = 0; i < 8; i++) begin
            if (!skip[i]) begin
                k++;
                repeat (dwell) addr_q.push_back(i);
            end
        end
        res_q.push_back('{mask: exp_mask, cnt: exp_cnt, done_cyc: k * dwell + 1});

        @(posedge clk); #1;
        drive_skip(on1, skip);
        drive_start(on1, 1'b1);
        @(posedge clk); #1;
        drive_start(on1, 1'b0);
        cyc = 1;
        while (!seen && cyc <= 60) begin
            drive_start(on1, retrig && cyc == 3);
            if (cyc == 2) drive_skip(on1, ~skip);
            if (s_valid) begin
                if (addr_q.size() == 0) check({tag, "_extra_valid"}, s_valid, 0);
                else                    check({tag, "_addr"}, s_addr, addr_q.pop_front());
            end
            check({tag, "_busy"}, s_busy, s_valid);
            if (s_done) begin
                seen = 1'b1;
                r = res_q.pop_front();
                check({tag, "_done_cycle"}, cyc, r.done_cyc);
                check({tag, "_err_mask"}, s_mask, r.mask);
                check({tag, "_err_count"}, s_cnt, r.cnt);
                check({tag, "_addr_left"}, addr_q.size(), 0);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        drive_start(on1, 1'b0);
        check({tag, "_done_seen"}, seen, 1);
        addr_q.delete();
        res_q.delete();
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, s_done, 0);
        check({tag, "_hold_mask"}, s_mask, exp_mask);
        check({tag, "_hold_cnt"}, s_cnt, exp_cnt);
    endtask

    initial begin
        int  n;
        bit  hit;
        rst_n = 1'b0;
        bus2.start = 1'b0; bus2.skip_mask = 8'h00;
        bus1.start = 1'b0; bus1.skip_mask = 8'h00;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset2");
        sel = 1'b1;
        check_idle("reset1");
        rst_n = 1'b1;

        mode2 = 0;
        scan(1'b0, 8'h00, 1'b0, 8'h00, 4'd0, "clean");
        mode2 = 1;
        scan(1'b0, 8'h00, 1'b0, 8'h40, 4'd1, "missing6");
        mode2 = 2;
        scan(1'b0, 8'hAA, 1'b0, 8'h00, 4'd0, "skipAA");
        mode2 = 0;
        scan(1'b0, 8'hFF, 1'b0, 8'h00, 4'd0, "skipFF");
        mode1 = 3;
        scan(1'b1, 8'h00, 1'b1, 8'hFF, 4'd8, "stuck");

        // Abort a dirty scan at address 3, then confirm a clean rescan.
        mode2 = 1;
        sel = 1'b0;
        @(posedge clk); #1;
        bus2.skip_mask = 8'h00;
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 40) begin
            if (bus2.addr_valid && bus2.addr == 3'd3) hit = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("mid_reach_addr3", hit, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle("mid_reset");
        rst_n = 1'b1;
        mode2 = 0;
        scan(1'b0, 8'h00, 1'b0, 8'h00, 4'd0, "post_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
